// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns (seg[6]=a .. seg[0]=g),
// decoded-digit record and the frame-capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       err;
    } seg7_digit_t;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to digit decoder; unknown patterns flag err,
// all-off flags blank, and both report value 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]  pattern,
    output seg7_digit_t digit
);

    always_comb begin
        digit = '0;
        case (pattern)
            SEG_0:     digit.value = 4'd0;
            SEG_1:     digit.value = 4'd1;
            SEG_2:     digit.value = 4'd2;
            SEG_3:     digit.value = 4'd3;
            SEG_4:     digit.value = 4'd4;
            SEG_5:     digit.value = 4'd5;
            SEG_6:     digit.value = 4'd6;
            SEG_7:     digit.value = 4'd7;
            SEG_8:     digit.value = 4'd8;
            SEG_9:     digit.value = 4'd9;
            SEG_BLANK: digit.blank = 1'b1;
            default:   digit.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures stable digits from a multiplexed 7-segment bus and presents a
// complete decoded frame through a valid/ready handshake.
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SAMP_W = 7 + NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SAMP_W-1:0]       prev_q, prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    seg7_digit_t             slot_q [NUM_DIGITS];
    seg7_digit_t             slot_d [NUM_DIGITS];
    seg7_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] frame_digits_q, frame_digits_d;
    logic [NUM_DIGITS-1:0]   frame_blank_q, frame_blank_d;
    logic [NUM_DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                    frame_valid_q, frame_valid_d;

    logic                    sel_onehot;
    logic                    same_sample;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   cap_bits;
    logic [NUM_DIGITS-1:0]   mask_after;
    seg7_digit_t             dec;

    seg7_pattern_decode u_decode (
        .pattern (seg),
        .digit   (dec)
    );

    assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);

    // Stability filter: a capture fires once, on the edge the run reaches STABLE_CYCLES.
    always_comb begin
        prev_d      = {seg, dig_sel};
        same_sample = (prev_d == prev_q);
        cnt_d       = '0;
        capture     = 1'b0;
        if (sel_onehot) begin
            if (!same_sample) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
            capture = (cnt_d == CNT_MAX) && !(same_sample && (cnt_q == CNT_MAX));
        end
        cap_bits   = capture ? dig_sel : '0;
        mask_after = mask_q | cap_bits;
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            slot_d[i] = cap_bits[i] ? dec : slot_q[i];
        end

        state_d        = state_q;
        mask_d         = mask_after;
        frame_digits_d = frame_digits_q;
        frame_blank_d  = frame_blank_q;
        frame_err_d    = frame_err_q;

        case (state_q)
            COLLECT: begin
                if (capture && (&mask_after)) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        frame_digits_d[4*i +: 4] = slot_d[i].value;
                        frame_blank_d[i]         = slot_d[i].blank;
                        frame_err_d[i]           = slot_d[i].err;
                    end
                    mask_d  = '0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // A digit captured on the accept edge still counts toward the next frame.
                if (frame_ready) begin
                    mask_d  = cap_bits;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        frame_valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q         <= '0;
            cnt_q          <= '0;
            mask_q         <= '0;
            state_q        <= COLLECT;
            frame_digits_q <= '0;
            frame_blank_q  <= '0;
            frame_err_q    <= '0;
            frame_valid_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            state_q        <= state_d;
            frame_digits_q <= frame_digits_d;
            frame_blank_q  <= frame_blank_d;
            frame_err_q    <= frame_err_d;
            frame_valid_q  <= frame_valid_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign frame_digits = frame_digits_q;
    assign frame_blank  = frame_blank_q;
    assign frame_err    = frame_err_q;
    assign frame_valid  = frame_valid_q;

endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Receive side of the binary-to-7-segment path. Samples a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and waits for each digit's pattern to be stable.
- Decodes each stable pattern back to a 4-bit binary value, with blank and illegal-pattern flags, and assembles a complete multi-digit frame.
- Hands the frame downstream through a valid/ready handshake. Sits between display-driver logic (or an external display tap) and the self-check/readback logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=1); width of dig_sel.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=1).
- CNT_W, localparam, $clog2(STABLE_CYCLES+1), stability counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- seg  in  7  segment lines, active-high; seg[6]=a … seg[0]=g.
- dig_sel  in  NUM_DIGITS  digit select, one-hot when valid; bit i = digit i.
- frame_digits  out  4*NUM_DIGITS  decoded values; digit i at [4i+3:4i].
- frame_blank  out  NUM_DIGITS  digit i was all-segments-off.
- frame_err  out  NUM_DIGITS  digit i was an illegal pattern.
- frame_valid  out  1  frame available.
- frame_ready  in  1  downstream accepts frame.

Behaviour:
- Decode table: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000 gives value 0 and blank=1.
  - Any other pattern gives value 0 and err=1.
  - blank and err are never both set.
- Stability filter:
  - Previous sample of {seg,dig_sel} is registered every cycle.
  - run counter = number of consecutive edges sampling the same {seg,dig_sel} with dig_sel one-hot; saturates at STABLE_CYCLES.
  - Counter clears to 0 when dig_sel is zero or multi-hot.
  - When dig_sel is one-hot but {seg,dig_sel} differs from the previous sample, the counter restarts at 1.
  - Capture occurs exactly once per stable window, at the edge where the counter reaches STABLE_CYCLES. With STABLE_CYCLES=1 that is the first edge sampling the new one-hot value.
- Capture: writes the decoded value/blank/err into working slot i and sets mask[i]. Recapturing an already-set digit overwrites its slot.
- FSM, 2 states:
  - COLLECT: frame_valid=0. At the edge where a capture makes mask all-ones, the frame registers load the working slots (including that capture), mask clears, and the state goes to PRESENT. frame_valid=1 is visible the next cycle.
  - PRESENT: frame_valid=1; frame registers are held constant. Captures continue into the working slots and mask. A full mask does not transfer while in PRESENT; it waits.
  - PRESENT exit: on an edge with frame_valid && frame_ready, return to COLLECT and clear mask. Exception: a capture on that same edge keeps its mask bit set.
  - A frame already fully collected when accepted is loaded on the next COLLECT capture edge that completes the mask.
- frame_ready is ignored while frame_valid=0.
- Reset (async assert, sync-released flops):
  - state=COLLECT; mask=0; counter=0; previous sample=0.
  - Working slots and frame_digits/blank/err = 0; frame_valid=0.
  - Reset mid-frame discards partial and presented frames; nothing is emitted after release until NUM_DIGITS new captures.
- Latency: final digit stable for STABLE_CYCLES samples → frame_valid high 1 cycle after the capture edge.

Decomposition:
- Package seg7_pkg: SEG_0..SEG_9 and SEG_BLANK 7-bit constants (shared with the encoder), the decoded-digit struct {value[3:0], blank, err}, and the FSM state enum {COLLECT, PRESENT}.
- Sub-module seg7_pattern_decode: purely combinational, 7-bit pattern in → value/blank/err out; instantiated once on the sampled seg.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=4. Hold digits 3,1,4,1 each for 6 cycles (dig_sel 0001,0010,0100,1000) → one frame: frame_digits=16'h1413, blank=0, err=0, frame_valid 1 cycle after the 4th stable sample of digit 3.
- Glitch: digit 0 pattern 1111001 held 3 cycles, then 1111011 held 4 cycles → captured value 9 only; no capture of 3.
- Illegal/blank: digit 2 = 1000000, digit 1 = 0000000 → frame_err=4'b0100, frame_blank=4'b0010, both values 0.
- Backpressure: frame_ready=0 for 20 cycles while new digits arrive → frame outputs unchanged, frame_valid stays 1. Raise frame_ready → the accept edge drops frame_valid; the next mask-complete capture produces the second frame.
- dig_sel=0011 or 0000 held 10 cycles → no capture, mask unchanged; a frame_ready/capture collision on the accept edge keeps that digit's mask bit.
- Assert rst_n=0 mid-collection (mask=0011) and during PRESENT → all outputs 0 asynchronously; after release, 4 fresh digits are required for the next frame.
